// File: rtl/issue_sequencer_if.sv
// issue_sequencer_if -- bundles the sequencer's ROM, decoder, ALU-compare,
// memory-completion and status signals.
//   master : the environment (ROM, decoder, ALU, memory, control)
//   slave  : the sequencer itself
// Signals:
//   start               begin execution at address 0
//   pc, fetch_en        ROM address and read strobe (data returns next cycle)
//   instr_in            ROM data
//   issue_valid/_instr  one-cycle issue pulse and the instruction to decode
//   cmp_valid/eq/gt     ALU compare result
//   mem_done            vector load/store completion
//   busy, halted        status
//   illegal             sticky illegal-opcode flag
//   retired             saturating executed-instruction counter
interface issue_sequencer_if #(
  parameter int unsigned ADDR_BITS  = 10,
  parameter int unsigned INSTR_BITS = 16
);
  logic                  start;
  logic [ADDR_BITS-1:0]  pc;
  logic                  fetch_en;
  logic [INSTR_BITS-1:0] instr_in;
  logic                  issue_valid;
  logic [INSTR_BITS-1:0] issue_instr;
  logic                  cmp_valid;
  logic                  cmp_eq;
  logic                  cmp_gt;
  logic                  mem_done;
  logic                  busy;
  logic                  halted;
  logic                  illegal;
  logic [15:0]           retired;

  modport master (
    output start, instr_in, cmp_valid, cmp_eq, cmp_gt, mem_done,
    input  pc, fetch_en, issue_valid, issue_instr, busy, halted, illegal, retired
  );

  modport slave (
    input  start, instr_in, cmp_valid, cmp_eq, cmp_gt, mem_done,
    output pc, fetch_en, issue_valid, issue_instr, busy, halted, illegal, retired
  );
endinterface

// File: rtl/issue_sequencer.sv
// issue_sequencer -- fetches instructions from a ROM, resolves jumps and END
// locally, forwards everything else to the decoder, and stalls on compare
// results and vector memory completion.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  issue_sequencer_if.slave (see the interface file for signal list)
// Opcodes (instr[3:0]): CMP=0, J=1, VLD=4, VSTR=5, END=14, 15 flags illegal;
// everything else issues as a plain instruction.
// Jumps: cond = instr[15:14] (00 eq, 01 gt, 10 always, 11 !eq),
//        target = instr[13:4].
module issue_sequencer #(
  parameter int unsigned ADDR_BITS  = 10,
  parameter int unsigned INSTR_BITS = 16
) (
  input logic              clk,
  input logic              rst,
  issue_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_CMP,
    S_WAIT_MEM,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_CMP  = 4'd0;
  localparam logic [3:0] OP_J    = 4'd1;
  localparam logic [3:0] OP_VLD  = 4'd4;
  localparam logic [3:0] OP_VSTR = 4'd5;
  localparam logic [3:0] OP_END  = 4'd14;
  localparam logic [3:0] OP_ILL  = 4'd15;

  state_t                state_q, state_d;
  logic [ADDR_BITS-1:0]  pc_q, pc_d;
  logic                  eq_q, eq_d;
  logic                  gt_q, gt_d;
  logic                  illegal_q, illegal_d;
  logic                  halted_q, halted_d;
  logic [15:0]           retired_q, retired_d;
  logic                  issue_valid_q, issue_valid_d;
  logic [INSTR_BITS-1:0] issue_instr_q, issue_instr_d;

  logic [3:0]            opcode;
  logic [ADDR_BITS-1:0]  pc_inc;
  logic [ADDR_BITS-1:0]  target;
  logic                  taken;

  assign opcode = bus.instr_in[3:0];
  assign target = bus.instr_in[4 +: ADDR_BITS];
  // Natural ADDR_BITS-wide overflow gives the wrap from the top address to 0.
  assign pc_inc = pc_q + ADDR_BITS'(1);

  always_comb begin
    taken = 1'b0;
    case (bus.instr_in[15:14])
      2'b00:   taken = eq_q;
      2'b01:   taken = gt_q;
      2'b10:   taken = 1'b1;
      default: taken = ~eq_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    eq_d          = eq_q;
    gt_d          = gt_q;
    illegal_d     = illegal_q;
    halted_d      = halted_q;
    retired_d     = retired_q;
    issue_valid_d = 1'b0;
    issue_instr_d = issue_instr_q;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (bus.start) begin
          pc_d      = '0;
          eq_d      = 1'b0;
          gt_d      = 1'b0;
          illegal_d = 1'b0;
          retired_d = '0;
          halted_d  = 1'b0;
          state_d   = S_FETCH;
        end
      end

      S_FETCH: state_d = S_ISSUE;

      S_ISSUE: begin
        // Every ISSUE exit retires, jumps and END included.
        retired_d = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;
        case (opcode)
          OP_J: begin
            pc_d    = taken ? target : pc_inc;
            state_d = S_FETCH;
          end
          OP_CMP: begin
            issue_valid_d = 1'b1;
            issue_instr_d = bus.instr_in;
            pc_d          = pc_inc;
            state_d       = S_WAIT_CMP;
          end
          OP_VLD, OP_VSTR: begin
            issue_valid_d = 1'b1;
            issue_instr_d = bus.instr_in;
            pc_d          = pc_inc;
            state_d       = S_WAIT_MEM;
          end
          OP_END: begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
          default: begin
            issue_valid_d = 1'b1;
            issue_instr_d = bus.instr_in;
            pc_d          = pc_inc;
            state_d       = S_FETCH;
            if (opcode == OP_ILL) illegal_d = 1'b1;
          end
        endcase
      end

      S_WAIT_CMP: begin
        if (bus.cmp_valid) begin
          eq_d    = bus.cmp_eq;
          gt_d    = bus.cmp_gt;
          state_d = S_FETCH;
        end
      end

      S_WAIT_MEM: begin
        if (bus.mem_done) state_d = S_FETCH;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      eq_q          <= 1'b0;
      gt_q          <= 1'b0;
      illegal_q     <= 1'b0;
      halted_q      <= 1'b0;
      retired_q     <= '0;
      issue_valid_q <= 1'b0;
      issue_instr_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      eq_q          <= eq_d;
      gt_q          <= gt_d;
      illegal_q     <= illegal_d;
      halted_q      <= halted_d;
      retired_q     <= retired_d;
      issue_valid_q <= issue_valid_d;
      issue_instr_q <= issue_instr_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.fetch_en    = (state_q == S_FETCH);
  assign bus.issue_valid = issue_valid_q;
  assign bus.issue_instr = issue_instr_q;
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign bus.halted      = halted_q;
  assign bus.illegal     = illegal_q;
  assign bus.retired     = retired_q;

endmodule
